imem_responder: RTL
===================

Name: imem_responder

Overview:
- Responder side of the CPU instruction-fetch interface: accepts a fetch request (byte address from the CPU's program counter) and returns a 32-bit instruction word after a configurable number of wait states.
- Replaces the zero-latency combinational instruction lookup so the CPU FETCH state can stall on a valid/ready handshake.
- Holds a word-addressed instruction array, preloaded through a side write port by the testbench or boot logic.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words (1024 words = 4 KiB).
- WAIT_STATES, 2, idle cycles between request acceptance and response valid (0..15).
- NOP_WORD, 32'h0000_0013, instruction returned on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-low: reset==0 at a rising edge resets the block.
- req_valid  in  1  CPU presents a fetch request.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (PC).
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_data  out  32  fetched instruction.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- load_en  in  1  preload write strobe.
- load_addr  in  DEPTH_LOG2  preload word index.
- load_data  in  32  preload word.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=00, wait counter=0, state=IDLE. The array is NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid&req_ready, latch req_addr and go to WAIT. If WAIT_STATES==0, go straight to RESP.
- WAIT: req_ready=0. The counter counts from 0 to WAIT_STATES-1, then the block goes to RESP.
- RESP entry: rsp_data and rsp_err are registered, and rsp_valid=1 in the first RESP cycle.
- Latency: with a request accepted at edge N, rsp_valid is first high in the cycle after edge N+WAIT_STATES+1.
- RESP: rsp_valid, rsp_data and rsp_err hold stable until rsp_valid&rsp_ready. On that edge: rsp_valid=0 and state=IDLE. req_ready returns to 1 in the following cycle, so there are no back-to-back accepts.
- Outstanding requests: exactly one. A req_valid during WAIT or RESP is ignored; the CPU holds req_valid and req_addr until it sees req_ready.
- Fault checks are made on the latched address, misaligned first:
  - addr[1:0]!=0 gives err=01.
  - Otherwise, addr[31:2] >= 2**DEPTH_LOG2 gives err=10.
  - On any fault, rsp_data=NOP_WORD.
- Normal read: rsp_data = array[addr[DEPTH_LOG2+1:2]].
- Load port: a write occurs on any edge with load_en=1, in any state, including while reset is asserted.
- Load/read collision: if a load hits the same index on the edge that registers rsp_data, read-before-write applies and the old word is returned.
- Reset mid-operation: reset with state WAIT or RESP drops the in-flight request. rsp_valid is 0 the next cycle, and no response is ever produced for that request.
- Address wrap: none. An out-of-range address never aliases.

Test Plan:
- Basic fetch: preload array[0]=32'h00500093, WAIT_STATES=2, request addr 0 -> rsp_valid first high 3 cycles after accept, data 32'h00500093, err 00.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/data/err stable all 5 cycles; a new req_valid is not accepted (req_ready=0); on accept, req_ready=1 the next cycle.
- Faults:
  - Request 32'h0000_0006 -> err 01, data 32'h00000013.
  - Request 32'h0000_1000 (word 1024, DEPTH_LOG2=10) -> err 10, data NOP.
  - Request 32'h0000_1002 -> err 01 (misaligned takes priority).
- Reset mid-WAIT: accept a request, assert reset low for 1 cycle during WAIT -> no rsp_valid ever appears; next request at addr 4 returns array[1] correctly; preloaded contents are intact.
- Zero wait / collision: WAIT_STATES=0, accept addr 8, pulse load_en to index 2 on the RESP-entry edge -> response carries the old word; a second fetch of addr 8 returns the new word.
- Sequential stream: 16 fetches at addrs 0,4,…,60 with rsp_ready randomized -> data matches the preload in order, no drops or duplicates.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch request at a time over a
// valid/ready handshake, waits WAIT_STATES cycles plus one array-read cycle,
// then presents the instruction word (or NOP_WORD with an error code).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The CPU holds req_valid/req_addr until it sees req_ready; the block
// holds rsp_valid/rsp_data/rsp_err until it sees rsp_ready.
module imem_responder #(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [1:0]            rsp_err,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [3:0]              cnt;
   logic [3:0]              cnt_next;
   logic                    accept;
   logic                    fetch;
   logic                    release_rsp;
   logic [31:0]             addr_q;
   logic                    misaligned;
   logic                    out_of_range;
   logic [DEPTH_LOG2-1:0]   word_idx;
   logic [31:0]             mem [0:DEPTH-1];

   // Fault classification of the latched address; misalignment wins.
   // Any set bit above the array index means out of range (no aliasing).
   assign misaligned   = (addr_q[1:0] != 2'b00);
   assign out_of_range = (addr_q[31:DEPTH_LOG2+2] != '0);
   assign word_idx     = addr_q[DEPTH_LOG2+1:2];

   // Next-state logic. WAIT spends WAIT_STATES idle cycles and one extra
   // cycle for the array read, so a request accepted at edge N is answered
   // at edge N+WAIT_STATES+1 (with zero wait states only the read cycle).
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      accept      = 1'b0;
      fetch       = 1'b0;
      release_rsp = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               cnt_next   = 4'd0;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == WS_CNT) begin
               fetch      = 1'b1;
               cnt_next   = 4'd0;
               state_next = S_RESP;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_valid && rsp_ready) begin
               release_rsp = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // req_ready is registered from the current state, so it rises one cycle
   // after returning to IDLE; this rules out back-to-back accepts.
   always_ff @(posedge clk) begin
      if (!reset) begin
         req_ready <= 1'b0;
      end else begin
         req_ready <= (state == S_IDLE) && !accept;
      end
   end

   // Capture the fetch address on accept.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q <= 32'd0;
      end else if (accept) begin
         addr_q <= req_addr;
      end
   end

   // Response registers: loaded on RESP entry, held until the CPU takes them.
   // The array read here sees the pre-edge contents, so a same-edge preload
   // to the same index returns the old word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_err   <= ERR_OK;
      end else if (fetch) begin
         rsp_valid <= 1'b1;
         if (misaligned) begin
            rsp_data <= NOP_WORD;
            rsp_err  <= ERR_ALIGN;
         end else if (out_of_range) begin
            rsp_data <= NOP_WORD;
            rsp_err  <= ERR_RANGE;
         end else begin
            rsp_data <= mem[word_idx];
            rsp_err  <= ERR_OK;
         end
      end else if (release_rsp) begin
         rsp_valid <= 1'b0;
      end
   end

   // Preload port: writes on any edge, independent of reset and FSM state.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule
